regfile_scoreboard: RTL and testbench

Parametrised integer register file for the pipelined core: configurable width, depth and number of read ports, with a per-register busy scoreboard for in-flight producers.
- Decode reserves destination registers at issue; writeback stores the result and releases the reservation.
- Read ports return data plus a per-port `busy` flag, so the hazard unit can stall without its own tracking logic.
- Replaces the fixed 2-read, 32×32 file in the new pipeline.

---
 rtl/regfile_scoreboard.sv | 140 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with per-register busy scoreboard
//
// Purpose:
//    Integer register file for the pipelined core. Decode reserves destination
//    registers at issue and writeback stores the result and releases the
//    reservation. Every read port returns data plus a busy flag, so the hazard
//    unit can stall without keeping its own tracking state.
//
// Parameters:
//    XLEN      data width in bits
//    NREG      number of registers (power of two, >= 2)
//    NRD       number of read ports (1..4)
//    ZERO_REG  1: register 0 reads as 0 and ignores writes and reservations
//
// Ports:
//    clk               in   1         rising-edge clock
//    reset_n           in   1         asynchronous active-low reset
//    reg_write_enable  in   1         commit write_data to write_address
//    write_address     in   AW        writeback destination
//    write_data        in   XLEN      writeback value
//    reserve_enable    in   1         mark reserve_address busy
//    reserve_address   in   AW        destination being reserved
//    flush             in   1         clear every busy bit
//    read_address      in   NRD*AW    port k at [k*AW +: AW]
//    read_data         out  NRD*XLEN  port k at [k*XLEN +: XLEN]
//    read_busy         out  NRD       port k register has a reservation
//    busy_count        out  AW+1      number of busy registers
//
// Build option:
//    REGFILE_BYPASS_EN  when defined, a same-cycle write is forwarded to
//                       matching read ports (write-first); otherwise reads
//                       see only stored state (read-before-write).

module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                reg_write_enable,
   input  logic [AW-1:0]       write_address,
   input  logic [XLEN-1:0]     write_data,
   input  logic                reserve_enable,
   input  logic [AW-1:0]       reserve_address,
   input  logic                flush,
   input  logic [NRD*AW-1:0]   read_address,
   output logic [NRD*XLEN-1:0] read_data,
   output logic [NRD-1:0]      read_busy,
   output logic [AW:0]         busy_count
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [AW:0]     count_nxt;
   logic            write_ok;
   logic            reserve_ok;

   // Address 0 is inert when ZERO_REG is set, so it is filtered once here and
   // never reaches storage or the busy vector.
   always_comb begin
      write_ok   = reg_write_enable;
      reserve_ok = reserve_enable;
      if (ZERO_REG != 0) begin
         if (write_address == '0)
            write_ok = 1'b0;
         if (reserve_address == '0)
            reserve_ok = 1'b0;
      end
   end

   // Busy next state; later assignments win, giving flush > reserve > write.
   always_comb begin
      busy_nxt = busy;
      if (write_ok)
         busy_nxt[write_address] = 1'b0;
      if (reserve_ok)
         busy_nxt[reserve_address] = 1'b1;
      if (flush)
         busy_nxt = '0;
   end

   // busy_count is registered from the next-state vector so it always equals
   // popcount(busy) without a cycle of lag.
   always_comb begin
      count_nxt = '0;
      for (int i = 0; i < NREG; i++)
         count_nxt = count_nxt + (AW+1)'(busy_nxt[i]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_nxt;
         busy_count <= count_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (write_ok) begin
         regs[write_address] <= write_data;
      end
   end

   // Read ports: independent combinational lookups.
   always_comb begin
      read_data = '0;
      read_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         logic [AW-1:0]   ra;
         logic [XLEN-1:0] rd;
         logic            rb;
         ra = read_address[k*AW +: AW];
         rd = regs[ra];
         rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
         // write_ok already excludes register 0 when it is hardwired.
         if (write_ok && (write_address == ra)) begin
            rd = write_data;
            rb = reserve_enable && (reserve_address == ra);
         end
`endif
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
            rb = 1'b0;
         end
         read_data[k*XLEN +: XLEN] = rd;
         read_busy[k]              = rb;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard

module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk;
   logic          reset_n;
   logic          reg_write_enable;
   logic [3:0]    write_address;
   logic [31:0]   write_data;
   logic          reserve_enable;
   logic [3:0]    reserve_address;
   logic          flush;
   logic [15:0]   read_address;
   logic [127:0]  read_data;
   logic [3:0]    read_busy;
   logic [4:0]    busy_count;

   int n_assert;
   int n_fail;

   regfile_scoreboard #(
      .XLEN(32), .NREG(16), .NRD(4), .ZERO_REG(1)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .reg_write_enable(reg_write_enable),
      .write_address(write_address),
      .write_data(write_data),
      .reserve_enable(reserve_enable),
      .reserve_address(reserve_address),
      .flush(flush),
      .read_address(read_address),
      .read_data(read_data),
      .read_busy(read_busy),
      .busy_count(busy_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] port_data(input int k);
      return read_data[k*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reg_write_enable = 1'b0;
      reserve_enable   = 1'b0;
      flush            = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset_n          = 1'b0;
      reg_write_enable = 1'b0;
      write_address    = '0;
      write_data       = '0;
      reserve_enable   = 1'b0;
      reserve_address  = '0;
      flush            = 1'b0;
      read_address     = '0;
      #2;

      // Reset state on every address and every port.
      for (int a = 0; a < 16; a++) begin
         read_address = {4{4'(a)}};
         #1;
         for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_data a%0d p%0d", a, k), port_data(k), 32'h0);
            check($sformatf("reset_busy a%0d p%0d", a, k), 32'(read_busy[k]), 32'h0);
         end
      end
      check("reset_count", 32'(busy_count), 32'h0);

      tick();
      reset_n = 1'b1;
      tick();

      // Write r5 and read it the same cycle.
      write_address    = 4'd5;
      write_data       = 32'hDEADBEEF;
      reg_write_enable = 1'b1;
      read_address     = 16'h0005;
      #1;
      check("r5_same_cycle", port_data(0), BYP ? 32'hDEADBEEF : 32'h0);
      tick();
      idle();
      #1;
      check("r5_next_cycle", port_data(0), 32'hDEADBEEF);

      // Register 0 ignores writes and reservations.
      write_address    = 4'd0;
      write_data       = 32'h55;
      reg_write_enable = 1'b1;
      reserve_address  = 4'd0;
      reserve_enable   = 1'b1;
      read_address     = 16'h0000;
      #1;
      check("r0_same_data", port_data(0), 32'h0);
      check("r0_same_busy", 32'(read_busy[0]), 32'h0);
      tick();
      idle();
      #1;
      check("r0_data", port_data(0), 32'h0);
      check("r0_busy", 32'(read_busy[0]), 32'h0);
      check("r0_count", 32'(busy_count), 32'h0);

      // Reserve r7, then r9.
      read_address    = 16'h0097;  // p0=r7, p1=r9
      reserve_address = 4'd7;
      reserve_enable  = 1'b1;
      #1;
      check("r7_busy_before_edge", 32'(read_busy[0]), 32'h0);
      tick();
      reserve_address = 4'd9;
      #1;
      check("count_after_r7", 32'(busy_count), 32'd1);
      check("r7_busy", 32'(read_busy[0]), 32'h1);
      tick();
      idle();
      #1;
      check("count_after_r9", 32'(busy_count), 32'd2);
      check("r9_busy", 32'(read_busy[1]), 32'h1);

      // Write r7 releases it.
      write_address    = 4'd7;
      write_data       = 32'h12;
      reg_write_enable = 1'b1;
      #1;
      check("r7_release_same_busy", 32'(read_busy[0]), BYP ? 32'h0 : 32'h1);
      check("r7_release_same_data", port_data(0), BYP ? 32'h12 : 32'h0);
      tick();
      idle();
      #1;
      check("r7_free", 32'(read_busy[0]), 32'h0);
      check("r7_data", port_data(0), 32'h12);
      check("count_after_r7_wr", 32'(busy_count), 32'd1);

      // Reserve and write r9 together: stays busy, new data stored.
      write_address    = 4'd9;
      write_data       = 32'h99;
      reg_write_enable = 1'b1;
      reserve_address  = 4'd9;
      reserve_enable   = 1'b1;
      #1;
      check("r9_rw_same_busy", 32'(read_busy[1]), 32'h1);
      check("r9_rw_same_data", port_data(1), BYP ? 32'h99 : 32'h0);
      tick();
      idle();
      #1;
      check("r9_rw_busy", 32'(read_busy[1]), 32'h1);
      check("r9_rw_data", port_data(1), 32'h99);
      check("r9_rw_count", 32'(busy_count), 32'd1);

      // Reserve r3, r4, r5, then flush with a reserve of r6.
      reserve_enable = 1'b1;
      for (int r = 3; r <= 5; r++) begin
         reserve_address = 4'(r);
         tick();
      end
      idle();
      read_address = 16'h6543;
      #1;
      check("count_before_flush", 32'(busy_count), 32'd4);
      check("busy_before_flush", 32'(read_busy), 32'h7);
      flush           = 1'b1;
      reserve_address = 4'd6;
      reserve_enable  = 1'b1;
      tick();
      idle();
      #1;
      check("flush_busy", 32'(read_busy), 32'h0);
      check("flush_count", 32'(busy_count), 32'd0);
      read_address = 16'h0009;
      #1;
      check("flush_r9_busy", 32'(read_busy[0]), 32'h0);

      // All four ports on busy r15.
      write_address    = 4'd15;
      write_data       = 32'hCAFEF00D;
      reg_write_enable = 1'b1;
      tick();
      idle();
      reserve_address = 4'd15;
      reserve_enable  = 1'b1;
      tick();
      idle();
      read_address = 16'hFFFF;
      #1;
      check("r15_busy_all", 32'(read_busy), 32'hF);
      for (int k = 0; k < 4; k++)
         check($sformatf("r15_data p%0d", k), port_data(k), 32'hCAFEF00D);
      check("r15_count", 32'(busy_count), 32'd1);

      // Asynchronous reset mid-cycle.
      reserve_address = 4'd2;
      reserve_enable  = 1'b1;
      tick();
      idle();
      read_address = 16'h52F0;  // p0=r0, p1=r15, p2=r2, p3=r5
      #1;
      check("pre_reset_count", 32'(busy_count), 32'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_count", 32'(busy_count), 32'd0);
      check("async_reset_busy", 32'(read_busy), 32'h0);
      check("async_reset_r15", port_data(1), 32'h0);
      check("async_reset_r5", port_data(3), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
